// File: rtl/lcd_ctrl_pkg.sv
// lcd_ctrl_pkg: shared opcode/state encodings and geometry helper for the LCD controller
package lcd_ctrl_pkg;
   typedef enum logic [3:0] {
      OP_WRITE = 4'd0, OP_UP, OP_DOWN, OP_LEFT, OP_RIGHT, OP_MAX, OP_MIN, OP_AVG,
      OP_CCW, OP_CW, OP_MIRX, OP_MIRY, OP_CENTRE, OP_RSV13, OP_RSV14, OP_RSV15
   } op_t;
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CMD, S_EXEC, S_WRITE, S_DONE} state_t;
   function automatic int centre(input int n);
      return n / 2;
   endfunction
endpackage

// File: rtl/lcd_win_alu.sv
// lcd_win_alu: combinational 2x2 window transform (max/min/avg/rotate/mirror)
module lcd_win_alu import lcd_ctrl_pkg::*; #(
   parameter int PIX_W = 8
) (
   input  op_t              op,
   input  logic [PIX_W-1:0] ul,
   input  logic [PIX_W-1:0] ur,
   input  logic [PIX_W-1:0] dl,
   input  logic [PIX_W-1:0] dr,
   output logic [PIX_W-1:0] n_ul,
   output logic [PIX_W-1:0] n_ur,
   output logic [PIX_W-1:0] n_dl,
   output logic [PIX_W-1:0] n_dr
);
   logic [PIX_W-1:0] mx_u, mx_d, mx, mn_u, mn_d, mn, avg;
   logic [PIX_W+1:0] sum;
   // reductions shared by max/min/average; sum carries two guard bits so avg never wraps
   always_comb begin
      mx_u = ul > ur ? ul : ur;
      mx_d = dl > dr ? dl : dr;
      mx   = mx_u > mx_d ? mx_u : mx_d;
      mn_u = ul < ur ? ul : ur;
      mn_d = dl < dr ? dl : dr;
      mn   = mn_u < mn_d ? mn_u : mn_d;
      sum  = {2'b00, ul} + {2'b00, ur} + {2'b00, dl} + {2'b00, dr};
      avg  = sum[PIX_W+1:2];
   end
   // new window contents; non-window opcodes pass the pixels through unchanged
   always_comb begin
      {n_ul, n_ur, n_dl, n_dr} = {ul, ur, dl, dr};
      case (op)
         OP_MAX:  {n_ul, n_ur, n_dl, n_dr} = {4{mx}};
         OP_MIN:  {n_ul, n_ur, n_dl, n_dr} = {4{mn}};
         OP_AVG:  {n_ul, n_ur, n_dl, n_dr} = {4{avg}};
         OP_CCW:  {n_ul, n_ur, n_dl, n_dr} = {ur, dr, ul, dl};
         OP_CW:   {n_ul, n_ur, n_dl, n_dr} = {dl, ul, dr, ur};
         OP_MIRX: {n_ul, n_ur, n_dl, n_dr} = {dl, dr, ul, ur};
         OP_MIRY: {n_ul, n_ur, n_dl, n_dr} = {ur, ul, dr, dl};
         default: ;
      endcase
   end
endmodule

// File: rtl/lcd_ctrl_param.sv
// lcd_ctrl_param: loads a frame from IROM, applies host window commands, streams it to IRAM
module lcd_ctrl_param import lcd_ctrl_pkg::*; #(
   parameter  int IMG_W   = 8,
   parameter  int IMG_H   = 8,
   parameter  int PIX_W   = 8,
   parameter  int ROM_LAT = 1,
   localparam int AW      = $clog2(IMG_W * IMG_H)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       cmd,
   input  logic             cmd_valid,
   input  logic [PIX_W-1:0] IROM_Q,
   output logic             IROM_rd,
   output logic [AW-1:0]    IROM_A,
   output logic             IRAM_valid,
   output logic [PIX_W-1:0] IRAM_D,
   output logic [AW-1:0]    IRAM_A,
   output logic             busy,
   output logic             done
);
   localparam int NPIX = IMG_W * IMG_H;
   localparam int XW   = $clog2(IMG_W);
   localparam int YW   = $clog2(IMG_H);
   localparam int CW   = $clog2(NPIX + ROM_LAT + 1);
   state_t st, nx;
   op_t op;
   logic [CW-1:0] cnt;
   logic [XW-1:0] px;
   logic [YW-1:0] py;
   logic [PIX_W-1:0] mem [NPIX];
   logic [AW-1:0] i_ul, i_ur, i_dl, i_dr;
   logic [PIX_W-1:0] w_ul, w_ur, w_dl, w_dr, n_ul, n_ur, n_dl, n_dr;
   logic accept, win_we, load_last, write_last;
   assign op = op_t'(cmd);
   // command handshake and phase-end strobes
   always_comb begin
      accept     = st == S_CMD && cmd_valid;
      win_we     = accept && op >= OP_MAX && op <= OP_MIRY;
      load_last  = cnt == CW'(NPIX + ROM_LAT - 1);
      write_last = cnt == CW'(NPIX - 1);
   end
   // state register
   always_ff @(posedge clk or negedge reset)
      if (!reset) st <= S_IDLE;
      else st <= nx;
   // next-state logic
   always_comb begin
      nx = st;
      case (st)
         S_IDLE:  nx = S_LOAD;
         S_LOAD:  nx = load_last ? S_CMD : S_LOAD;
         S_CMD:   nx = !cmd_valid ? S_CMD : op == OP_WRITE ? S_WRITE : S_EXEC;
         S_EXEC:  nx = S_CMD;
         S_WRITE: nx = write_last ? S_DONE : S_WRITE;
         S_DONE:  nx = S_IDLE;
         default: nx = S_IDLE;
      endcase
   end
   // outputs decoded from state and the shared phase counter, so reset clears them at once
   always_comb begin
      IROM_rd    = st == S_LOAD && cnt < CW'(NPIX);
      IROM_A     = IROM_rd ? AW'(cnt) : '0;
      IRAM_valid = st == S_WRITE;
      IRAM_A     = IRAM_valid ? AW'(cnt) : '0;
      IRAM_D     = IRAM_valid ? mem[AW'(cnt)] : '0;
      busy       = st != S_CMD;
      done       = st == S_DONE;
   end
   // phase counter restarts on every state change; point moves saturate inside 1..size-1
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         cnt <= '0;
         px  <= XW'(centre(IMG_W));
         py  <= YW'(centre(IMG_H));
      end else begin
         cnt <= st != nx ? '0 : cnt + 1'b1;
         if (accept) begin
            px <= op == OP_LEFT && px > XW'(1) ? px - 1'b1 :
                  op == OP_RIGHT && px < XW'(IMG_W - 1) ? px + 1'b1 :
                  op == OP_CENTRE ? XW'(centre(IMG_W)) : px;
            py <= op == OP_UP && py > YW'(1) ? py - 1'b1 :
                  op == OP_DOWN && py < YW'(IMG_H - 1) ? py + 1'b1 :
                  op == OP_CENTRE ? YW'(centre(IMG_H)) : py;
         end
      end
   // window indices: IMG_W is a power of two, so row*IMG_W+col is a concatenation
   always_comb begin
      i_ul = AW'({py - 1'b1, px - 1'b1});
      i_ur = i_ul + AW'(1);
      i_dl = i_ul + AW'(IMG_W);
      i_dr = i_dl + AW'(1);
      w_ul = mem[i_ul];
      w_ur = mem[i_ur];
      w_dl = mem[i_dl];
      w_dr = mem[i_dr];
   end
   lcd_win_alu #(.PIX_W(PIX_W)) u_alu (
      .op(op), .ul(w_ul), .ur(w_ur), .dl(w_dl), .dr(w_dr),
      .n_ul(n_ul), .n_ur(n_ur), .n_dl(n_dl), .n_dr(n_dr)
   );
   // frame buffer: ROM data lands ROM_LAT cycles after its address; window ops write all four at once
   always_ff @(posedge clk) begin
      if (st == S_LOAD && cnt >= CW'(ROM_LAT)) mem[AW'(cnt - CW'(ROM_LAT))] <= IROM_Q;
      if (win_we) begin
         mem[i_ul] <= n_ul;
         mem[i_ur] <= n_ur;
         mem[i_dl] <= n_dl;
         mem[i_dr] <= n_dr;
      end
   end
endmodule

// File: tb/tb_lcd_ctrl_param.sv
// tb_lcd_ctrl_param: directed + random checks of the LCD controller against an array model
module tb_lcd_ctrl_param;
   logic clk = 1'b0;
   logic reset;
   logic [3:0] cmd, cmd2;
   logic cmd_valid, v2;
   logic [7:0] q1;
   logic [9:0] q2a, q2b;
   logic rd1, rd2, iv1, iv2, busy, busy2, done, done2;
   logic [5:0] ra1, ra2, ia1, ia2;
   logic [7:0] id1;
   logic [9:0] id2;
   logic [7:0] rom [64];
   logic [7:0] mbuf [64];
   logic [7:0] cap [64];
   logic [9:0] rom2 [64];
   int mpx, mpy, checks, errors;
   int w_rd, w_len, w_first, w_bad, w_iram, w_rd2, w_len2;

   always #5 clk = ~clk;

   lcd_ctrl_param dut (
      .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid), .IROM_Q(q1),
      .IROM_rd(rd1), .IROM_A(ra1), .IRAM_valid(iv1), .IRAM_D(id1), .IRAM_A(ia1),
      .busy(busy), .done(done)
   );
   lcd_ctrl_param #(.IMG_W(16), .IMG_H(4), .PIX_W(10), .ROM_LAT(2)) dut2 (
      .clk(clk), .reset(reset), .cmd(cmd2), .cmd_valid(v2), .IROM_Q(q2b),
      .IROM_rd(rd2), .IROM_A(ra2), .IRAM_valid(iv2), .IRAM_D(id2), .IRAM_A(ia2),
      .busy(busy2), .done(done2)
   );

   always @(posedge clk) begin
      q1  <= rom[ra1];
      q2a <= rom2[ra2];
      q2b <= q2a;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Model: window as a clockwise ring UL,UR,DR,DL around point (mpx,mpy)
   function automatic void apply(input int op);
      int idx[4];
      int v[4];
      int r[4];
      int s, mx, mn;
      idx = '{(mpy-1)*8 + mpx-1, (mpy-1)*8 + mpx, mpy*8 + mpx, mpy*8 + mpx-1};
      s = 0; mx = 0; mn = 255;
      for (int k = 0; k < 4; k++) begin
         v[k] = int'(mbuf[idx[k]]);
         s += v[k];
         if (v[k] > mx) mx = v[k];
         if (v[k] < mn) mn = v[k];
      end
      if (op == 1 && mpy > 1) mpy--;
      else if (op == 2 && mpy < 7) mpy++;
      else if (op == 3 && mpx > 1) mpx--;
      else if (op == 4 && mpx < 7) mpx++;
      else if (op == 12) begin mpx = 4; mpy = 4; end
      else if (op >= 5 && op <= 11) begin
         for (int k = 0; k < 4; k++)
            r[k] = op == 5 ? mx : op == 6 ? mn : op == 7 ? s / 4 :
                   op == 8 ? v[(k+1)%4] : op == 9 ? v[(k+3)%4] :
                   op == 10 ? v[3-k] : v[k^1];
         for (int k = 0; k < 4; k++) mbuf[idx[k]] = 8'(r[k]);
      end
   endfunction

   task automatic wait_cmd;
      int k = 0;
      while (busy && k < 300) begin @(negedge clk); k++; end
      chk("cmd_ready", {31'd0, busy}, 0);
   endtask

   task automatic send(input int op);
      wait_cmd();
      cmd = 4'(op);
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      if (op != 0) apply(op);
   endtask

   // Runs a frame load on both DUTs and records its shape; model reloads from the ROM
   task automatic wait_ready;
      int k = 0;
      bit s1 = 0, s2 = 0;
      w_rd = 0; w_len = 0; w_first = -1; w_bad = 0; w_iram = 0; w_rd2 = 0; w_len2 = 0;
      do begin
         @(negedge clk);
         k++;
         if (rd1) begin
            if (ra1 !== 6'(w_rd)) w_bad++;
            if (!s1) w_first = k;
            s1 = 1; w_rd++;
         end
         if (s1 && busy) w_len++;
         if (rd2) begin
            if (ra2 !== 6'(w_rd2)) w_bad++;
            s2 = 1; w_rd2++;
         end
         if (s2 && busy2) w_len2++;
         if (iv1) w_iram++;
      end while ((busy || busy2) && k < 500);
      chk("load_finished", {30'd0, busy, busy2}, 0);
      chk("load_addr_seq", w_bad, 0);
      mbuf = rom;
   endtask

   task automatic write_check(input string tag);
      send(0);
      for (int i = 0; i < 64; i++) begin
         checks++;
         assert (iv1 === 1'b1 && ia1 === 6'(i) && id1 === mbuf[i]) else begin
            errors++;
            $error("FAIL %s word %0d: valid=%b A=%0d D=%0d, expected valid=1 A=%0d D=%0d",
                   tag, i, iv1, ia1, id1, i, mbuf[i]);
         end
         cap[i] = id1;
         @(negedge clk);
      end
      chk({tag, "_done"}, {30'd0, done, iv1}, 2);
      @(negedge clk);
      chk({tag, "_done_pulse"}, {31'd0, done}, 0);
      wait_ready();
      chk({tag, "_rd_restart"}, w_first, 1);
      chk({tag, "_reload_rd"}, w_rd, 64);
      chk({tag, "_reload_len"}, w_len, 65);
   endtask

   initial begin
      checks = 0; errors = 0;
      reset = 1'b0; cmd = '0; cmd_valid = 1'b0; cmd2 = '0; v2 = 1'b0;
      mpx = 4; mpy = 4;
      for (int i = 0; i < 64; i++) begin
         rom[i]  = 8'(i);
         rom2[i] = 10'((i * 37) % 1024);
      end
      rom2[23] = 10'd1023; rom2[24] = 10'd1023; rom2[39] = 10'd1023; rom2[40] = 10'd1023;
      #13;
      chk("rst_IROM_rd", {31'd0, rd1}, 0);
      chk("rst_IROM_A", {26'd0, ra1}, 0);
      chk("rst_IRAM_valid", {31'd0, iv1}, 0);
      chk("rst_IRAM_D", {24'd0, id1}, 0);
      chk("rst_IRAM_A", {26'd0, ia1}, 0);
      chk("rst_busy", {31'd0, busy}, 1);
      chk("rst_done", {31'd0, done}, 0);
      @(negedge clk);
      reset = 1'b1;
      wait_ready();
      chk("load1_rd", w_rd, 64);
      chk("load1_len", w_len, 65);
      chk("load2_rd", w_rd2, 64);
      chk("load2_len", w_len2, 66);

      // wide-pixel, latency-2 instance: average of an all-1023 window, then a full write
      begin
         int n = 0, first = -1, last = -1, bad = 0;
         logic [9:0] w23;
         cmd2 = 4'd7; v2 = 1'b1;
         @(negedge clk); v2 = 1'b0;
         @(negedge clk); cmd2 = 4'd0; v2 = 1'b1;
         @(negedge clk); v2 = 1'b0;
         w23 = '0;
         for (int k = 0; k < 80; k++) begin
            if (iv2) begin
               if (first < 0) first = k;
               last = k;
               if (ia2 !== 6'(n) || id2 !== rom2[n]) bad++;
               if (n == 23) w23 = id2;
               n++;
            end
            @(negedge clk);
         end
         chk("w2_count", n, 64);
         chk("w2_contiguous", last - first + 1, 64);
         chk("w2_data", bad, 0);
         chk("w2_avg_no_overflow", {22'd0, w23}, 1023);
      end

      write_check("ident");
      chk("ident_0", {24'd0, cap[0]}, 0);
      chk("ident_63", {24'd0, cap[63]}, 63);

      send(5);
      send(6);
      write_check("maxmin");
      chk("max_27", {24'd0, cap[27]}, 36);
      chk("max_28", {24'd0, cap[28]}, 36);
      chk("max_35", {24'd0, cap[35]}, 36);
      chk("min_36", {24'd0, cap[36]}, 36);
      chk("outside_26", {24'd0, cap[26]}, 26);

      send(7);
      rom[0] = 8'd10; rom[1] = 8'd20; rom[8] = 8'd30; rom[9] = 8'd40;
      write_check("avg");
      chk("avg_27", {24'd0, cap[27]}, 31);
      chk("avg_36", {24'd0, cap[36]}, 31);

      repeat (5) send(1);
      repeat (9) send(3);
      send(9);
      for (int i = 0; i < 64; i++) rom[i] = 8'($urandom_range(0, 255));
      write_check("cw");
      chk("cw_0", {24'd0, cap[0]}, 30);
      chk("cw_1", {24'd0, cap[1]}, 10);
      chk("cw_8", {24'd0, cap[8]}, 40);
      chk("cw_9", {24'd0, cap[9]}, 20);

      // command held across the EXEC cycle must not be taken twice
      wait_cmd();
      cmd = 4'd4; cmd_valid = 1'b1;
      @(negedge clk);
      chk("exec_busy", {31'd0, busy}, 1);
      cmd = 4'd2;
      @(negedge clk);
      cmd_valid = 1'b0;
      apply(4);
      chk("held_cmd_ignored", {31'd0, busy}, 0);
      send(14);
      chk("rsv_busy", {31'd0, busy}, 1);
      @(negedge clk);
      chk("rsv_one_cycle", {31'd0, busy}, 0);
      send(5);

      repeat (150) send(int'($urandom_range(1, 15)));
      for (int i = 0; i < 64; i++) rom[i] = 8'($urandom_range(0, 255));
      write_check("rand");

      // asynchronous reset in the middle of a write
      send(0);
      begin
         int k = 0;
         while (ia1 !== 6'd20 && k < 100) begin @(negedge clk); k++; end
      end
      chk("reached_word_20", {26'd0, ia1}, 20);
      #1 reset = 1'b0;
      #1;
      chk("arst_IRAM_valid", {31'd0, iv1}, 0);
      chk("arst_IRAM_A", {26'd0, ia1}, 0);
      chk("arst_IRAM_D", {24'd0, id1}, 0);
      chk("arst_busy", {31'd0, busy}, 1);
      chk("arst_IROM_rd", {31'd0, rd1}, 0);
      chk("arst_done", {31'd0, done}, 0);
      @(negedge clk);
      reset = 1'b1;
      mpx = 4; mpy = 4;
      wait_ready();
      chk("arst_no_iram", w_iram, 0);
      chk("arst_reload_rd", w_rd, 64);
      chk("arst_reload_len", w_len, 65);
      chk("arst_reload2_len", w_len2, 66);
      send(5);
      repeat (60) send(int'($urandom_range(1, 15)));
      write_check("post_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
